// File: rtl/decode_format_arbiter.sv
// rtl/decode_format_arbiter.sv - merges per-format decoder results into one in-order decode stream
module decode_format_arbiter #(
  parameter int numDecoders             = 4,
  parameter int payloadWidth            = 128,
  parameter int instructionCounterWidth = 64,
  parameter int idWidth                 = 2
) (
  input  logic                                           clock_i,
  input  logic                                           reset_i,
  input  logic [numDecoders-1:0]                         enable_i,
  input  logic [numDecoders*instructionCounterWidth-1:0] majId_i,
  input  logic [numDecoders*payloadWidth-1:0]            payload_i,
  input  logic                                           stall_i,
  output logic [numDecoders-1:0]                         stall_o,
  output logic                                           enable_o,
  output logic [instructionCounterWidth-1:0]             majId_o,
  output logic [payloadWidth-1:0]                        payload_o,
  output logic [idWidth-1:0]                             decoderId_o,
  output logic                                           overflow_o
);

  localparam int IW = instructionCounterWidth;
  localparam int PW = payloadWidth;

  logic [numDecoders-1:0] valid_q, valid_d;
  logic [IW-1:0]          buf_maj_q [numDecoders];
  logic [PW-1:0]          buf_pay_q [numDecoders];
  logic [numDecoders-1:0] capture;

  logic                   enable_q, enable_d;
  logic [IW-1:0]          maj_q, maj_d;
  logic [PW-1:0]          pay_q, pay_d;
  logic [idWidth-1:0]     id_q, id_d;
  logic                   overflow_q, overflow_d;

  logic                   win_found;
  logic [idWidth-1:0]     win_idx;
  logic [IW-1:0]          win_maj;
  logic [PW-1:0]          win_pay;
  logic                   grant;

  // Strict less-than keeps the lowest index on equal major IDs.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_maj   = '0;
    win_pay   = '0;
    for (int i = 0; i < numDecoders; i++) begin
      if (valid_q[i] && (!win_found || buf_maj_q[i] < win_maj)) begin
        win_found = 1'b1;
        win_idx   = idWidth'(i);
        win_maj   = buf_maj_q[i];
        win_pay   = buf_pay_q[i];
      end
    end
  end

  assign grant = !stall_i && win_found;

  always_comb begin
    capture    = enable_i & ~valid_q;
    valid_d    = valid_q | capture;
    overflow_d = overflow_q | (|(enable_i & valid_q));
    enable_d   = enable_q;
    maj_d      = maj_q;
    pay_d      = pay_q;
    id_d       = id_q;
    if (grant) begin
      valid_d[win_idx] = 1'b0;
      enable_d         = 1'b1;
      maj_d            = win_maj;
      pay_d            = win_pay;
      id_d             = win_idx;
    end else if (!stall_i) begin
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      valid_q    <= '0;
      enable_q   <= 1'b0;
      maj_q      <= '0;
      pay_q      <= '0;
      id_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      enable_q   <= enable_d;
      maj_q      <= maj_d;
      pay_q      <= pay_d;
      id_q       <= id_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents are only meaningful under valid_q, so they need no reset.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < numDecoders; i++) begin
      if (capture[i]) begin
        buf_maj_q[i] <= majId_i[(numDecoders-1-i)*IW +: IW];
        buf_pay_q[i] <= payload_i[(numDecoders-1-i)*PW +: PW];
      end
    end
  end

  assign stall_o     = valid_q;
  assign enable_o    = enable_q;
  assign majId_o     = maj_q;
  assign payload_o   = pay_q;
  assign decoderId_o = id_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_decode_format_arbiter.sv
// tb/tb_decode_format_arbiter.sv - scoreboard bench for decode_format_arbiter
module tb_decode_format_arbiter;

  localparam int N  = 4;
  localparam int PW = 128;
  localparam int IW = 64;
  localparam int DW = 2;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b0;
  logic [N-1:0]      enable_i = '0;
  logic [N*IW-1:0]   majId_i = '0;
  logic [N*PW-1:0]   payload_i = '0;
  logic              stall_i = 1'b0;
  logic [N-1:0]      stall_o;
  logic              enable_o;
  logic [IW-1:0]     majId_o;
  logic [PW-1:0]     payload_o;
  logic [DW-1:0]     decoderId_o;
  logic              overflow_o;

  decode_format_arbiter #(
    .numDecoders(N), .payloadWidth(PW), .instructionCounterWidth(IW), .idWidth(DW)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .majId_i(majId_i),
    .payload_i(payload_i), .stall_i(stall_i), .stall_o(stall_o), .enable_o(enable_o),
    .majId_o(majId_o), .payload_o(payload_o), .decoderId_o(decoderId_o),
    .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [IW-1:0] maj;
    logic [PW-1:0] pay;
    int            id;
  } item_t;

  item_t         exp_q[$];
  int            checks = 0;
  int            failures = 0;

  // Reference state: one pending bundle slot per decoder.
  bit            m_full [N];
  logic [IW-1:0] m_maj  [N];
  logic [PW-1:0] m_pay  [N];
  bit            m_ovf;

  logic [IW-1:0] maj_v [N];
  logic [PW-1:0] pay_v [N];

  function automatic logic [N-1:0] model_stall();
    logic [N-1:0] s;
    for (int i = 0; i < N; i++) s[i] = m_full[i];
    return s;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One cycle: drive inputs at the falling edge and advance the reference model
  // to the state it must hold right after the following rising edge.
  task automatic cycle(input logic [N-1:0] en, input bit st, input bit rst = 1'b1);
    bit pre [N];
    int w;
    @(negedge clock_i);
    reset_i  = rst;
    enable_i = en;
    stall_i  = st;
    for (int i = 0; i < N; i++) begin
      majId_i[(N-1-i)*IW +: IW]   = maj_v[i];
      payload_i[(N-1-i)*PW +: PW] = pay_v[i];
    end
    if (!rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_ovf = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) pre[i] = m_full[i];
      if (!st) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (pre[i] && (w < 0 || {m_maj[i], i[7:0]} < {m_maj[w], w[7:0]})) w = i;
        if (w >= 0) begin
          exp_q.push_back('{maj: m_maj[w], pay: m_pay[w], id: w});
          m_full[w] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (en[i] && pre[i]) m_ovf = 1;
        if (en[i] && !pre[i]) begin
          m_full[i] = 1;
          m_maj[i]  = maj_v[i];
          m_pay[i]  = pay_v[i];
        end
      end
    end
  endtask

  task automatic randomize_inputs(input int maj_range);
    for (int i = 0; i < N; i++) begin
      maj_v[i] = 64'($urandom_range(maj_range));
      pay_v[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Monitor: samples just after each rising edge, decoupled from stimulus.
  initial begin
    logic          p_en = 0;
    logic [IW-1:0] p_maj = '0;
    logic [PW-1:0] p_pay = '0;
    logic [DW-1:0] p_id = '0;
    item_t         e;
    forever begin
      @(posedge clock_i);
      #1;
      if (!reset_i) begin
        check("reset_outputs", {enable_o, overflow_o, stall_o, decoderId_o},
              256'(0));
        check("reset_data", {majId_o, payload_o}, 256'(0));
      end else begin
        check("stall_o", 256'(stall_o), 256'(model_stall()));
        check("overflow_o", 256'(overflow_o), 256'(m_ovf));
        if (stall_i) begin
          check("hold", {enable_o, decoderId_o, majId_o, payload_o},
                {p_en, p_id, p_maj, p_pay});
        end else if (enable_o) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_grant: got id=%0d maj=%0h expected none",
                     decoderId_o, majId_o);
          end else begin
            e = exp_q.pop_front();
            check("grant", {decoderId_o, majId_o, payload_o},
                  {DW'(e.id), e.maj, e.pay});
          end
        end else begin
          check("missing_grant", 256'(exp_q.size()), 256'(0));
        end
      end
      p_en = enable_o; p_maj = majId_o; p_pay = payload_o; p_id = decoderId_o;
    end
  end

  initial begin
    int budget;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; maj_v[i] = '0; pay_v[i] = '0;
    end
    m_ovf = 0;
    cycle('0, 0, 0);
    cycle('0, 0, 0);

    randomize_inputs(3);
    maj_v[2] = 64'd5;
    cycle(4'b0100, 0);
    repeat (3) cycle('0, 0);

    randomize_inputs(3);
    maj_v[0] = 64'd9; maj_v[3] = 64'd7;
    cycle(4'b1001, 0);
    repeat (3) cycle('0, 0);

    randomize_inputs(3);
    maj_v[1] = 64'd4; maj_v[2] = 64'd4;
    cycle(4'b0110, 0);
    repeat (3) cycle('0, 0);

    randomize_inputs(20);
    cycle(4'b1011, 0);
    repeat (3) cycle('0, 1);
    repeat (5) cycle('0, 0);

    randomize_inputs(20);
    cycle(4'b0010, 1);
    randomize_inputs(20);
    cycle(4'b0010, 1);
    repeat (4) cycle('0, 0);

    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] en;
      randomize_inputs(15);
      en = N'($urandom);
      if ($urandom_range(9) != 0) en = en & ~model_stall();
      cycle(en, $urandom_range(9) < 3);
    end

    randomize_inputs(50);
    cycle(4'b1101, 1);
    cycle('0, 1);
    cycle('0, 0, 0);
    repeat (4) cycle('0, 0);

    randomize_inputs(7);
    cycle(4'b1111, 0);
    budget = 0;
    while ((exp_q.size() != 0 || model_stall() != '0) && budget < 50) begin
      cycle('0, 0);
      budget++;
    end
    cycle('0, 0);
    check("drain_timeout", 256'(budget < 50), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
